// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) helpers and constants for the AES MixColumns datapath.
// Also holds the FSM state type used by the mix_columns_engine sequencer.
package aes_gf_pkg;

  localparam logic [7:0] GF_POLY = 8'h1B;

  // Element k is the coefficient applied to row-k byte in output row 0;
  // each further output row rotates this vector right by one.
  localparam logic [3:0][3:0] FWD_COEF = {4'h1, 4'h1, 4'h3, 4'h2};
  localparam logic [3:0][3:0] INV_COEF = {4'h9, 4'hD, 4'hB, 4'hE};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Coefficients are compile-time constants, so the masks fold away and only
  // the xtime chain and the XOR tree remain.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{c[0]}} & b) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction

endpackage

// File: rtl/gf_mix_column.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column.
// Row 0 is the most significant byte of col_in and col_out.
module gf_mix_column
  import aes_gf_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inverse,
  output logic [31:0] col_out
);

  logic [3:0][7:0] a;
  logic [3:0][7:0] fwd;
  logic [3:0][7:0] inv;

  for (genvar k = 0; k < 4; k++) begin : g_split
    assign a[k] = col_in[31-8*k -: 8];
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign fwd[r] = gf_mul_const(a[0], FWD_COEF[(4-r)%4]) ^
                    gf_mul_const(a[1], FWD_COEF[(5-r)%4]) ^
                    gf_mul_const(a[2], FWD_COEF[(6-r)%4]) ^
                    gf_mul_const(a[3], FWD_COEF[(7-r)%4]);
    assign inv[r] = gf_mul_const(a[0], INV_COEF[(4-r)%4]) ^
                    gf_mul_const(a[1], INV_COEF[(5-r)%4]) ^
                    gf_mul_const(a[2], INV_COEF[(6-r)%4]) ^
                    gf_mul_const(a[3], INV_COEF[(7-r)%4]);
    assign col_out[31-8*r -: 8] = inverse ? inv[r] : fwd[r];
  end

endmodule

// File: rtl/mix_columns_engine.sv
// Handshaked AES MixColumns / InvMixColumns engine processing COLS_PER_CYCLE
// columns per clock; mode is captured with each block.
module mix_columns_engine
  import aes_gf_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] MAX_OFF  = 2'(COLS_PER_CYCLE - 1);

  state_e          state_q, state_d;
  logic [3:0][31:0] work_q, work_d;
  logic            inverse_q, inverse_d;
  logic [1:0]      col_idx_q, col_idx_d;

  logic [3:0][31:0] in_cols;
  logic [3:0][31:0] run_next;
  logic [3:0][31:0] mix_out_full;
  logic [COLS_PER_CYCLE-1:0][31:0] mix_in;
  logic [COLS_PER_CYCLE-1:0][31:0] mix_out;
  logic [COLS_PER_CYCLE-1:0][1:0]  col_sel;
  logic [3:0][1:0] col_off;
  logic            accept;

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
    assign col_sel[g] = col_idx_q + 2'(g);
    assign mix_in[g]  = work_q[col_sel[g]];

    gf_mix_column u_col (
      .col_in  (mix_in[g]),
      .inverse (inverse_q),
      .col_out (mix_out[g])
    );
  end

  // Lanes beyond COLS_PER_CYCLE are never selected; tie them off so the
  // per-column write-back can index a fixed four-entry array.
  for (genvar g = 0; g < 4; g++) begin : g_pad
    if (g < COLS_PER_CYCLE) begin : g_used
      assign mix_out_full[g] = mix_out[g];
    end else begin : g_unused
      assign mix_out_full[g] = '0;
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign in_cols[c]              = in_state[127-32*c -: 32];
    assign out_state[127-32*c -: 32] = work_q[c];
    assign col_off[c]  = 2'(c) - col_idx_q;
    assign run_next[c] = (col_off[c] <= MAX_OFF) ? mix_out_full[col_off[c]] : work_q[c];
  end

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    inverse_d = inverse_q;
    col_idx_d = col_idx_q;
    case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        work_d    = run_next;
        col_idx_d = col_idx_q + COL_STEP;
        if (col_idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A load in DONE overrides the return to IDLE so back-to-back blocks skip a bubble.
    if (accept) begin
      work_d    = in_cols;
      inverse_d = in_inverse;
      col_idx_d = 2'd0;
      state_d   = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      work_q    <= '0;
      inverse_q <= 1'b0;
      col_idx_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      inverse_q <= inverse_d;
      col_idx_q <= col_idx_d;
    end
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed-vector bench for mix_columns_engine, driving three instances with
// COLS_PER_CYCLE = 1, 2 and 4 one at a time.
module tb_mix_columns_engine;

  localparam logic [127:0] VEC_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_B = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_C = 128'hd5d5d7d6_01010101_c6c6c6c6_01010101;
  localparam logic [127:0] VEC_D = 128'hd4d4d4d5_01010101_c6c6c6c6_01010101;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] in_state;
  logic         in_inverse;
  logic         in_valid    [3];
  logic         out_ready   [3];
  logic         in_ready_w  [3];
  logic         out_valid_w [3];
  logic         busy_w      [3];
  logic [127:0] out_state_w [3];

  int n_checks = 0;
  int n_fails  = 0;

  logic [127:0] tbl_in  [6];
  logic [127:0] tbl_exp [6];
  logic         tbl_inv [6];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_engine #(.COLS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready_w[g]),
      .in_state   (in_state),
      .in_inverse (in_inverse),
      .out_valid  (out_valid_w[g]),
      .out_ready  (out_ready[g]),
      .out_state  (out_state_w[g]),
      .busy       (busy_w[g])
    );
  end

  function automatic int run_cycles(input int d);
    return 4 / (1 << d);
  endfunction

  task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the input handshake.
  task automatic send_block(input int d, input logic [127:0] s, input logic inv);
    int guard;
    guard = 0;
    while (!in_ready_w[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready_w[d]) check_output($sformatf("d%0d in_ready timeout", d), 0, 1);
    in_state    = s;
    in_inverse  = inv;
    in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_inverse  = ~inv;
    in_state    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // lat counts cycles since the handshake; out_valid should rise at N+1.
  task automatic wait_valid(input int d, output int lat);
    lat = 1;
    while (!out_valid_w[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid_w[d]) check_output($sformatf("d%0d out_valid timeout", d), 0, 1);
  endtask

  task automatic accept_result(input int d, input bit rand_ready, output logic [127:0] res);
    int guard;
    bit r;
    guard = 0;
    r = 1'b0;
    res = out_state_w[d];
    while (!r && guard < 50) begin
      r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready[d] = r;
      res = out_state_w[d];
      @(negedge clk);
      guard++;
    end
    out_ready[d] = 1'b0;
  endtask

  task automatic directed(input int d, input logic [127:0] s, input logic inv,
                          input logic [127:0] exp, input string name);
    int lat;
    logic [127:0] res;
    send_block(d, s, inv);
    check_output($sformatf("d%0d %s busy", d, name), busy_w[d], 1);
    wait_valid(d, lat);
    check_output($sformatf("d%0d %s latency", d, name), lat, run_cycles(d) + 1);
    accept_result(d, 1'b0, res);
    check_output($sformatf("d%0d %s state", d, name), res, exp);
    check_output($sformatf("d%0d %s idle after", d, name), out_valid_w[d], 0);
  endtask

  task automatic backpressure(input int d);
    int lat;
    logic [127:0] res;
    send_block(d, VEC_A, 1'b0);
    wait_valid(d, lat);
    for (int i = 0; i < 7; i++) begin
      check_output($sformatf("d%0d bp valid c%0d", d, i), out_valid_w[d], 1);
      check_output($sformatf("d%0d bp state c%0d", d, i), out_state_w[d], VEC_B);
      check_output($sformatf("d%0d bp in_ready c%0d", d, i), in_ready_w[d], 0);
      @(negedge clk);
    end
    out_ready[d] = 1'b1;
    in_valid[d]  = 1'b1;
    in_state     = VEC_B;
    in_inverse   = 1'b1;
    #1;
    check_output($sformatf("d%0d bp release in_ready", d), in_ready_w[d], 1);
    @(negedge clk);
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b0;
    in_inverse   = 1'b0;
    in_state     = '0;
    wait_valid(d, lat);
    check_output($sformatf("d%0d bp reload latency", d), lat, run_cycles(d) + 1);
    accept_result(d, 1'b0, res);
    check_output($sformatf("d%0d bp reload state", d), res, VEC_A);
  endtask

  task automatic back_to_back(input int d);
    int blk, res_n, last, cyc;
    logic accepted;
    blk = 0; res_n = 0; last = 0; cyc = 0;
    out_ready[d] = 1'b1;
    in_state     = tbl_in[0];
    in_inverse   = tbl_inv[0];
    in_valid[d]  = 1'b1;
    while (res_n < 6 && cyc < 200) begin
      if (out_valid_w[d]) begin
        check_output($sformatf("d%0d b2b result %0d", d, res_n), out_state_w[d], tbl_exp[res_n]);
        if (res_n > 0) check_output($sformatf("d%0d b2b spacing %0d", d, res_n), cyc - last, run_cycles(d) + 1);
        last = cyc;
        res_n++;
      end
      accepted = in_valid[d] && in_ready_w[d];
      @(posedge clk);
      #1;
      cyc++;
      if (accepted) begin
        blk++;
        if (blk < 6) begin
          in_state   = tbl_in[blk];
          in_inverse = tbl_inv[blk];
        end else begin
          in_valid[d] = 1'b0;
        end
      end
      @(negedge clk);
    end
    check_output($sformatf("d%0d b2b result count", d), res_n, 6);
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b0;
  endtask

  task automatic reset_mid_run();
    int stale;
    send_block(0, VEC_A, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("rst out_valid", out_valid_w[0], 0);
    check_output("rst in_ready", in_ready_w[0], 1);
    check_output("rst busy", busy_w[0], 0);
    check_output("rst out_state", out_state_w[0], 0);
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid_w[0]) stale++;
    end
    check_output("rst no stale result", stale, 0);
  endtask

  task automatic round_trip(input int d, input int blocks);
    int lat;
    logic [127:0] s, mid, back;
    for (int b = 0; b < blocks; b++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      send_block(d, s, 1'b0);
      wait_valid(d, lat);
      accept_result(d, 1'b1, mid);
      send_block(d, mid, 1'b1);
      wait_valid(d, lat);
      accept_result(d, 1'b1, back);
      check_output($sformatf("d%0d roundtrip %0d", d, b), back, s);
    end
  endtask

  initial begin
    tbl_in[0] = VEC_A; tbl_inv[0] = 1'b0; tbl_exp[0] = VEC_B;
    tbl_in[1] = VEC_B; tbl_inv[1] = 1'b1; tbl_exp[1] = VEC_A;
    tbl_in[2] = VEC_D; tbl_inv[2] = 1'b0; tbl_exp[2] = VEC_C;
    tbl_in[3] = VEC_C; tbl_inv[3] = 1'b1; tbl_exp[3] = VEC_D;
    tbl_in[4] = VEC_A; tbl_inv[4] = 1'b0; tbl_exp[4] = VEC_B;
    tbl_in[5] = VEC_B; tbl_inv[5] = 1'b1; tbl_exp[5] = VEC_A;

    reset      = 1'b1;
    in_state   = '0;
    in_inverse = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int d = 0; d < 3; d++) begin
      check_output($sformatf("d%0d reset out_valid", d), out_valid_w[d], 0);
      check_output($sformatf("d%0d reset in_ready", d), in_ready_w[d], 1);
      check_output($sformatf("d%0d reset busy", d), busy_w[d], 0);
      check_output($sformatf("d%0d reset out_state", d), out_state_w[d], 0);
    end

    for (int d = 0; d < 3; d++) begin
      $display("[TB] directed vectors, COLS_PER_CYCLE=%0d", 1 << d);
      directed(d, VEC_A, 1'b0, VEC_B, "fwd");
      directed(d, VEC_B, 1'b1, VEC_A, "inv");
      directed(d, VEC_C, 1'b1, VEC_D, "inv col0");
      directed(d, VEC_D, 1'b0, VEC_C, "fwd col0");
      backpressure(d);
      back_to_back(d);
    end

    $display("[TB] reset during RUN");
    reset_mid_run();

    for (int d = 0; d < 3; d++) begin
      $display("[TB] random round trip, COLS_PER_CYCLE=%0d", 1 << d);
      round_trip(d, 150);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
